// File: rtl/gba_sound_pkg.sv
// rtl/gba_sound_pkg.sv - shared types, constants and helpers for the GBA PSG channels
// Purpose: common definitions used by the square channels and, later, the noise channel.
// Contents: duty_t, env_dir_t, DUTY_HIGH_STEPS, LEN_MAX, FREQ_MAX, SWEEP_PERIOD_ZERO,
//           sweep_calc() (12-bit sweep target so overflow past 2047 stays visible).
package gba_sound_pkg;

  typedef enum logic [1:0] {
    DUTY_12 = 2'b00,
    DUTY_25 = 2'b01,
    DUTY_50 = 2'b10,
    DUTY_75 = 2'b11
  } duty_t;

  typedef enum logic {
    ENV_DOWN = 1'b0,
    ENV_UP   = 1'b1
  } env_dir_t;

  // Number of high steps out of 8 for each duty code; element [0] belongs to code 00.
  localparam logic [3:0][3:0] DUTY_HIGH_STEPS = {4'd6, 4'd4, 4'd2, 4'd1};

  localparam logic [6:0]  LEN_MAX           = 7'd64;
  localparam logic [10:0] FREQ_MAX          = 11'd2047;
  localparam logic [3:0]  SWEEP_PERIOD_ZERO = 4'd8;

  // New sweep frequency. Subtraction cannot underflow because (shadow >> shift) <= shadow.
  function automatic logic [11:0] sweep_calc(input logic [10:0] shadow,
                                             input logic        sub,
                                             input logic [2:0]  shift);
    logic [11:0] delta;
    delta = {1'b0, (shadow >> shift)};
    if (sub) begin
      sweep_calc = {1'b0, shadow} - delta;
    end else begin
      sweep_calc = {1'b0, shadow} + delta;
    end
  endfunction

endpackage

// File: rtl/square_envelope.sv
// rtl/square_envelope.sv - volume register with envelope timer, shared by square and noise channels
// Purpose: holds the 4-bit channel volume; loads it on trigger and steps it up or down
//          on every period-th envelope tick, saturating at 0 and 15.
// Ports:
//   clk_i       in   clock
//   reset_i     in   synchronous active-high reset
//   trigger_i   in   channel trigger; loads volume and envelope timer
//   tick_i      in   64 Hz envelope strobe
//   init_vol_i  in   4  initial volume loaded on trigger
//   dir_i       in   envelope direction
//   period_i    in   3  envelope period; 0 freezes the envelope
//   volume_o    out  4  current volume
module square_envelope
  import gba_sound_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       trigger_i,
  input  logic       tick_i,
  input  logic [3:0] init_vol_i,
  input  env_dir_t   dir_i,
  input  logic [2:0] period_i,
  output logic [3:0] volume_o
);

  logic [3:0] volume_q, volume_d;
  logic [2:0] timer_q, timer_d;

  always_comb begin
    volume_d = volume_q;
    timer_d  = timer_q;
    if (trigger_i) begin
      volume_d = init_vol_i;
      timer_d  = period_i;
    end else if (tick_i && (period_i != 3'd0)) begin
      // A timer of 0 can be left over from a trigger with period 0; treat it as expiring now.
      if (timer_q <= 3'd1) begin
        timer_d = period_i;
        if ((dir_i == ENV_UP) && (volume_q != 4'hF)) begin
          volume_d = volume_q + 4'd1;
        end else if ((dir_i == ENV_DOWN) && (volume_q != 4'h0)) begin
          volume_d = volume_q - 4'd1;
        end
      end else begin
        timer_d = timer_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      volume_q <= 4'd0;
      timer_q  <= 3'd0;
    end else begin
      volume_q <= volume_d;
      timer_q  <= timer_d;
    end
  end

  assign volume_o = volume_q;

endmodule

// File: rtl/square_sweep.sv
// rtl/square_sweep.sv - frequency sweep unit of square channel 1
// Purpose: keeps the shadow frequency and sweep timer; on trigger and on sweep-period
//          expiry computes the next frequency and flags overflow past 2047.
// Ports:
//   clk_i        in   clock
//   reset_i      in   synchronous active-high reset
//   trigger_i    in   channel trigger
//   tick_i       in   128 Hz sweep strobe
//   period_i     in   3  sweep period (0 behaves as 8 for the timer, disables updates)
//   sub_i        in   1 = subtract
//   shift_i      in   3  sweep shift
//   freq_trig_i  in   11 frequency as it stands after this cycle's register writes
//   overflow_o   out  disable request (combinational, valid this cycle)
//   freq_wr_o    out  write freq_o into the channel frequency (combinational)
//   freq_o       out  11 swept frequency
module square_sweep
  import gba_sound_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        trigger_i,
  input  logic        tick_i,
  input  logic [2:0]  period_i,
  input  logic        sub_i,
  input  logic [2:0]  shift_i,
  input  logic [10:0] freq_trig_i,
  output logic        overflow_o,
  output logic        freq_wr_o,
  output logic [10:0] freq_o
);

  logic [10:0] shadow_q, shadow_d;
  logic [3:0]  timer_q, timer_d;
  logic        en_q, en_d;
  logic [11:0] calc;
  logic [3:0]  reload;

  // On trigger the overflow check runs on the freshly loaded shadow value.
  assign calc   = sweep_calc(trigger_i ? freq_trig_i : shadow_q, sub_i, shift_i);
  assign reload = (period_i == 3'd0) ? SWEEP_PERIOD_ZERO : {1'b0, period_i};
  assign freq_o = calc[10:0];

  always_comb begin
    shadow_d   = shadow_q;
    timer_d    = timer_q;
    en_d       = en_q;
    overflow_o = 1'b0;
    freq_wr_o  = 1'b0;
    if (trigger_i) begin
      shadow_d = freq_trig_i;
      timer_d  = reload;
      en_d     = (period_i != 3'd0) || (shift_i != 3'd0);
      if ((shift_i != 3'd0) && (calc > {1'b0, FREQ_MAX})) begin
        overflow_o = 1'b1;
      end
    end else if (tick_i) begin
      if (timer_q <= 4'd1) begin
        timer_d = reload;
        if (en_q && (period_i != 3'd0)) begin
          if (calc > {1'b0, FREQ_MAX}) begin
            overflow_o = 1'b1;
          end else if (shift_i != 3'd0) begin
            shadow_d  = calc[10:0];
            freq_wr_o = 1'b1;
          end
        end
      end else begin
        timer_d = timer_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      shadow_q <= 11'd0;
      timer_q  <= 4'd0;
      en_q     <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      timer_q  <= timer_d;
      en_q     <= en_d;
    end
  end

endmodule

// File: rtl/square_channel.sv
// rtl/square_channel.sv - GBA PSG square channel (1 with sweep, 2 without)
// Purpose: duty-cycle square generator with length counter, volume envelope, optional
//          frequency sweep and trigger semantics; produces a signed volume-scaled sample.
// Ports:
//   system_clock  in   sole clock
//   reset         in   synchronous active-high reset
//   nrx0..nrx4    in   8  register levels (sweep, duty/length, envelope, freq lo, ctrl/freq hi)
//   nrx1_wr, nrx3_wr, nrx4_wr  in  1-cycle write strobes
//   len_tick, env_tick, sweep_tick  in  frame-sequencer strobes
//   wave          out  OUT_W signed sample (OUT_W >= 5)
//   enabled       out  channel active
//   freq_cur      out  11 current frequency
module square_channel
  import gba_sound_pkg::*;
#(
  parameter bit HAS_SWEEP = 1'b1,
  parameter int CLK_DIV   = 4,
  parameter int OUT_W     = 5
) (
  input  logic                    system_clock,
  input  logic                    reset,
  input  logic [7:0]              nrx0,
  input  logic [7:0]              nrx1,
  input  logic [7:0]              nrx2,
  input  logic [7:0]              nrx3,
  input  logic [7:0]              nrx4,
  input  logic                    nrx1_wr,
  input  logic                    nrx3_wr,
  input  logic                    nrx4_wr,
  input  logic                    len_tick,
  input  logic                    env_tick,
  input  logic                    sweep_tick,
  output logic signed [OUT_W-1:0] wave,
  output logic                    enabled,
  output logic [10:0]             freq_cur
);

  localparam int TW = 11 + $clog2(CLK_DIV);

  // Frequency timer period minus one, so the timer spends exactly the period at each step.
  function automatic logic [TW-1:0] period_of(input logic [10:0] f);
    period_of = TW'((32'd2048 - 32'(f)) * 32'(CLK_DIV) - 32'd1);
  endfunction

  logic                    trigger;
  logic                    dac_on;
  logic [10:0]             freq_trig;
  duty_t                   duty;
  logic [3:0]              volume;
  logic                    sweep_ovf;
  logic                    sweep_wr;
  logic [10:0]             sweep_freq;
  logic                    len_expire;
  logic                    high;
  logic [OUT_W-1:0]        mag;

  logic [10:0]             freq_q, freq_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [2:0]              duty_pos_q, duty_pos_d;
  logic [6:0]              len_q, len_d;
  logic                    en_q, en_d;
  logic signed [OUT_W-1:0] wave_q, wave_d;

  logic unused_nrx4;
  assign unused_nrx4 = ^nrx4[5:3];

  assign trigger   = nrx4_wr & nrx4[7];
  assign dac_on    = |nrx2[7:3];
  assign duty      = duty_t'(nrx1[7:6]);
  // Frequency including any byte written this cycle; a trigger uses it for reload and shadow.
  assign freq_trig = {nrx4_wr ? nrx4[2:0] : freq_q[10:8], nrx3_wr ? nrx3 : freq_q[7:0]};

  square_envelope u_env (
    .clk_i      (system_clock),
    .reset_i    (reset),
    .trigger_i  (trigger),
    .tick_i     (env_tick),
    .init_vol_i (nrx2[7:4]),
    .dir_i      (env_dir_t'(nrx2[3])),
    .period_i   (nrx2[2:0]),
    .volume_o   (volume)
  );

  generate
    if (HAS_SWEEP) begin : g_sweep
      logic unused_nrx0_msb;
      assign unused_nrx0_msb = nrx0[7];
      square_sweep u_sweep (
        .clk_i       (system_clock),
        .reset_i     (reset),
        .trigger_i   (trigger),
        .tick_i      (sweep_tick),
        .period_i    (nrx0[6:4]),
        .sub_i       (nrx0[3]),
        .shift_i     (nrx0[2:0]),
        .freq_trig_i (freq_trig),
        .overflow_o  (sweep_ovf),
        .freq_wr_o   (sweep_wr),
        .freq_o      (sweep_freq)
      );
    end else begin : g_no_sweep
      logic unused_sweep;
      assign unused_sweep = ^{nrx0, sweep_tick};
      assign sweep_ovf    = 1'b0;
      assign sweep_wr     = 1'b0;
      assign sweep_freq   = 11'd0;
    end
  endgenerate

  // Frequency register: CPU writes beat a sweep update landing in the same cycle.
  always_comb begin
    freq_d = freq_q;
    if (nrx3_wr || nrx4_wr) begin
      freq_d = freq_trig;
    end else if (sweep_wr) begin
      freq_d = sweep_freq;
    end
  end

  // Frequency timer and duty position.
  always_comb begin
    timer_d    = timer_q;
    duty_pos_d = duty_pos_q;
    if (trigger) begin
      timer_d    = period_of(freq_trig);
      duty_pos_d = 3'd0;
    end else if (timer_q == '0) begin
      timer_d    = period_of(freq_q);
      duty_pos_d = duty_pos_q + 3'd1;
    end else begin
      timer_d = timer_q - 1'b1;
    end
  end

  // Length counter: trigger, then write, then tick.
  always_comb begin
    len_d      = len_q;
    len_expire = 1'b0;
    if (trigger) begin
      if (len_q == 7'd0) begin
        len_d = LEN_MAX;
      end
    end else if (nrx1_wr) begin
      len_d = LEN_MAX - {1'b0, nrx1[5:0]};
    end else if (len_tick && nrx4[6] && (len_q != 7'd0)) begin
      len_d      = len_q - 7'd1;
      len_expire = (len_q == 7'd1);
    end
  end

  // Channel enable; the DAC check is last so it overrides everything.
  always_comb begin
    en_d = en_q;
    if (trigger) begin
      en_d = 1'b1;
    end
    if (len_expire || sweep_ovf) begin
      en_d = 1'b0;
    end
    if (!dac_on) begin
      en_d = 1'b0;
    end
  end

  // Output sample, registered from the current state so it trails it by one cycle.
  always_comb begin
    high = ({1'b0, duty_pos_q} < DUTY_HIGH_STEPS[duty]);
    mag  = {{(OUT_W-4){1'b0}}, volume};
    if (!en_q) begin
      wave_d = '0;
    end else if (high) begin
      wave_d = mag;
    end else begin
      wave_d = -mag;
    end
  end

  always_ff @(posedge system_clock) begin
    if (reset) begin
      freq_q     <= 11'd0;
      timer_q    <= '0;
      duty_pos_q <= 3'd0;
      len_q      <= 7'd0;
      en_q       <= 1'b0;
      wave_q     <= '0;
    end else begin
      freq_q     <= freq_d;
      timer_q    <= timer_d;
      duty_pos_q <= duty_pos_d;
      len_q      <= len_d;
      en_q       <= en_d;
      wave_q     <= wave_d;
    end
  end

  assign wave     = wave_q;
  assign enabled  = en_q;
  assign freq_cur = freq_q;

endmodule

// File: doc/square_channel.md
Name: square_channel

Overview:
Parametrised successor to the plain duty-cycle square generator. One GBA PSG square channel: channel 1 with `HAS_SWEEP=1`, channel 2 with `HAS_SWEEP=0`.
Adds length counter, volume envelope, optional frequency sweep, trigger semantics and a signed volume-scaled output. It runs single-clock with enable strobes instead of a derived timer clock.
Sits between the sound register file (NRx0–NRx4 levels plus write strobes) and the mixer. Frame-sequencer ticks arrive as 1-cycle strobes.

Parameters:
HAS_SWEEP, 1, 1 = sweep unit present (NRx0 honoured); 0 = NRx0 ignored, sweep logic absent
CLK_DIV, 4, system_clock cycles per frequency unit; duty step period = (2048-freq)*CLK_DIV
OUT_W, 5, signed output width; must be >= 5

Ports:
system_clock  in  1  sole clock, all state on posedge
reset  in  1  synchronous, active-high
nrx0  in  8  sweep: [6:4] period, [3] dir (1 = subtract), [2:0] shift
nrx1  in  8  [7:6] duty, [5:0] length load
nrx2  in  8  [7:4] initial volume, [3] env dir (1 = up), [2:0] env period
nrx3  in  8  freq[7:0]
nrx4  in  8  [7] trigger, [6] length enable, [2:0] freq[10:8]
nrx1_wr  in  1  1-cycle strobe, nrx1 written
nrx3_wr  in  1  1-cycle strobe, nrx3 written
nrx4_wr  in  1  1-cycle strobe, nrx4 written
len_tick  in  1  256 Hz strobe
env_tick  in  1  64 Hz strobe
sweep_tick  in  1  128 Hz strobe
wave  out  OUT_W  signed sample
enabled  out  1  channel active
freq_cur  out  11  current (possibly swept) frequency, for readback

Behaviour:
- Reset (sync, next edge): `enabled`=0, `wave`=0, `freq_cur`=0, `duty_pos`=0, `timer`=0, `volume`=0, `length_ctr`=0, sweep state cleared. A mid-operation reset aborts all activity.
- Frequency register:
  - `nrx3_wr` loads `freq_cur[7:0]`.
  - `nrx4_wr` loads `freq_cur[10:8]`.
  - A sweep update overwrites `freq_cur`.
- Frequency timer:
  - Down-counter of width 11+clog2(CLK_DIV).
  - At 0: reload (2048-freq_cur)*CLK_DIV-1 and advance `duty_pos` (3-bit, wraps 7→0).
  - freq=2047, CLK_DIV=4 gives one step every 4 cycles.
- Duty: high when `duty_pos` < N, with N = 1, 2, 4, 6 for duty codes 00, 01, 10, 11.
- Output, registered:
  - `wave` = +volume when enabled and high.
  - `wave` = -volume when enabled and low.
  - `wave` = 0 when disabled.
  - Sign-extended to OUT_W; updates the cycle after `duty_pos` or `volume` changes.
- DAC: if nrx2[7:3]==0, `enabled` is forced 0 every cycle and trigger does not set it.
- Trigger (`nrx4_wr` with nrx4[7]=1):
  - `enabled`=1 (DAC permitting).
  - `length_ctr`=64 if currently 0.
  - Timer reloaded, `duty_pos`=0.
  - `volume`=nrx2[7:4]; `env_timer`=nrx2[2:0].
  - If HAS_SWEEP: `shadow`=freq_cur; `sweep_timer`=period (0 treated as 8); `sweep_en`=(period!=0 || shift!=0).
  - If HAS_SWEEP and shift!=0: immediate overflow calc; result > 2047 → `enabled`=0.
- Length:
  - `nrx1_wr` loads `length_ctr`=64-nrx1[5:0].
  - On `len_tick` with nrx4[6]=1 and `length_ctr`!=0: decrement; reaching 0 → `enabled`=0.
- Envelope:
  - On `env_tick` with period!=0: decrement `env_timer`.
  - At 0: reload period, then up and `volume`<15 → +1, or down and `volume`>0 → −1.
  - Saturates; never wraps.
- Sweep (HAS_SWEEP only):
  - On `sweep_tick`: decrement `sweep_timer`; at 0 reload (0→8).
  - If `sweep_en` and period!=0: new = shadow ± (shadow>>shift), computed 12-bit.
  - new > 2047 → `enabled`=0.
  - Else if shift!=0: `shadow`=`freq_cur`=new.
  - Subtract never underflows: shadow>>shift ≤ shadow.
- Simultaneous events, priority: reset > trigger > register-write strobes > ticks.
  - A trigger and `len_tick` in the same cycle: trigger reload wins, no decrement that cycle.
  - `nrx1_wr` + `len_tick`: load wins.
  - Ticks while disabled still update counters; `wave` stays 0.

Decomposition:
- Package `gba_sound_pkg`:
  - `duty_t` enum.
  - `DUTY_HIGH_STEPS` constant array {1,2,4,6}.
  - `LEN_MAX`=64, `FREQ_MAX`=2047, `SWEEP_PERIOD_ZERO`=8.
  - `env_dir_t`.
- Sub-module `square_envelope`: volume plus envelope timer, with trigger load and tick inputs. It is shared later with the noise channel.
- The sweep unit is instantiated under `generate` if HAS_SWEEP.

Test Plan:
1. Duty: nrx2=0xF0, freq=2047, CLK_DIV=4, trigger, duty=10 → `wave` +15 for 16 cycles, −15 for 16 cycles, repeating. Duty 00 → +15 for 4 cycles then −15 for 28 cycles.
2. Length: nrx1[5:0]=62 written, nrx4=0xC7 trigger → `enabled` falls to 0 exactly on the 2nd `len_tick`, `wave`=0 next cycle. Trigger again → `length_ctr`=64.
3. Envelope: nrx2=0x31 (vol 3, down, period 1), trigger, 4 `env_tick` → `volume` 3,2,1,0,0; `wave`=0 magnitude, `enabled` stays 1.
4. Sweep: freq=0x400, nrx0=0x11 (period 1, add, shift 1), trigger, `sweep_tick` → `freq_cur`=0x600; next tick → 0x900 overflow, `enabled`=0.
5. DAC/trigger overflow: nrx2=0x00 + trigger → `enabled` stays 0. freq=0x7F0, shift 1, add, trigger → `enabled`=0 the same cycle.
6. Collisions/reset: trigger and `len_tick` same cycle with `length_ctr`=0 → `length_ctr`=64. Assert reset mid-tone → all outputs 0 after the next edge; HAS_SWEEP=0 instance ignores nrx0.
